// File: rtl/microsequencer_if.sv
// ============================================================================
// microsequencer_if : instruction/memory inputs and micro-PC outputs of the
//                     microsequencer. Rev 1.0
// ============================================================================
`default_nettype none

interface microsequencer_if #(
  parameter int UPC_W = 4,
  parameter int CNT_W = 16
);
  logic [6:0]       op;
  logic [1:0]       addr_ctl;
  logic             mem_wait;
  logic             mem_ready;
  logic [UPC_W-1:0] upc;
  logic             stall;
  logic             retire;
  logic             illegal_op;
  logic [CNT_W-1:0] instr_count;

  modport master (
    output op, addr_ctl, mem_wait, mem_ready,
    input  upc, stall, retire, illegal_op, instr_count
  );

  modport slave (
    input  op, addr_ctl, mem_wait, mem_ready,
    output upc, stall, retire, illegal_op, instr_count
  );
endinterface

`default_nettype wire

// File: rtl/microsequencer.sv
// ============================================================================
// microsequencer : micro-PC sequencer with two dispatch tables and a retire
//                  counter; MICROSEQ_ILLEGAL_TRAP_EN selects the trap build.
// Rev 1.0
// ============================================================================
`default_nettype none

module microsequencer #(
  parameter int UPC_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  microsequencer_if.slave  bus
);

`ifdef MICROSEQ_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  localparam logic [1:0] AC_FETCH = 2'b00;
  localparam logic [1:0] AC_DISP1 = 2'b01;
  localparam logic [1:0] AC_DISP2 = 2'b10;
  localparam logic [1:0] AC_SEQ   = 2'b11;

  logic [UPC_W-1:0] upc_q, upc_d;
  logic             retire_q, retire_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stall_w;
  logic             in_trap_w;
  logic [UPC_W:0]   disp_w;

  // Table entries are {valid, target}; valid=0 marks an unmapped opcode.
  function automatic logic [UPC_W:0] disp1(input logic [6:0] op_v);
    case (op_v)
      7'b0110011: disp1 = {1'b1, UPC_W'(6)};
      7'b0010011: disp1 = {1'b1, UPC_W'(8)};
      7'b1101111: disp1 = {1'b1, UPC_W'(9)};
      7'b1100011: disp1 = {1'b1, UPC_W'(10)};
      7'b0000011: disp1 = {1'b1, UPC_W'(2)};
      7'b0100011: disp1 = {1'b1, UPC_W'(2)};
      default:    disp1 = {1'b0, {UPC_W{1'b0}}};
    endcase
  endfunction

  function automatic logic [UPC_W:0] disp2(input logic [6:0] op_v);
    case (op_v)
      7'b0000011: disp2 = {1'b1, UPC_W'(3)};
      7'b0100011: disp2 = {1'b1, UPC_W'(5)};
      default:    disp2 = {1'b0, {UPC_W{1'b0}}};
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      upc_q     <= '0;
      retire_q  <= 1'b0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      upc_q     <= upc_d;
      retire_q  <= retire_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    upc_d     = upc_q;
    retire_d  = 1'b0;
    illegal_d = illegal_q;
    in_trap_w = TRAP_EN && (upc_q == {UPC_W{1'b1}});
    disp_w    = (bus.addr_ctl == AC_DISP1) ? disp1(bus.op) : disp2(bus.op);
    if (!stall_w && !in_trap_w) begin
      case (bus.addr_ctl)
        AC_FETCH: begin
          upc_d    = '0;
          retire_d = (upc_q != '0);
        end
        AC_SEQ: upc_d = upc_q + 1'b1;
        default: begin
          if (disp_w[UPC_W]) begin
            upc_d = disp_w[UPC_W-1:0];
          end else begin
            // Trap build parks in all-ones; otherwise retire as a NOP.
            illegal_d = 1'b1;
            upc_d     = TRAP_EN ? {UPC_W{1'b1}} : {UPC_W{1'b0}};
            retire_d  = !TRAP_EN;
          end
        end
      endcase
    end
    cnt_d = cnt_q + CNT_W'(retire_d);
  end

  always_comb begin
    stall_w         = bus.mem_wait & ~bus.mem_ready;
    bus.stall       = stall_w;
    bus.upc         = upc_q;
    bus.retire      = retire_q;
    bus.illegal_op  = illegal_q;
    bus.instr_count = cnt_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_microsequencer.sv
// ============================================================================
// tb_microsequencer : directed vectors for microsequencer, including a narrow
//                     counter instance for the wrap check. Rev 1.0
// ============================================================================
`default_nettype none

module tb_microsequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [6:0] op = '0;
  logic [1:0] addr_ctl = 2'b00;
  logic       mem_wait = 1'b0;
  logic       mem_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  microsequencer_if #(.UPC_W(4), .CNT_W(16)) bus ();
  microsequencer_if #(.UPC_W(4), .CNT_W(4))  bus4 ();

  assign bus.op         = op;
  assign bus.addr_ctl   = addr_ctl;
  assign bus.mem_wait   = mem_wait;
  assign bus.mem_ready  = mem_ready;
  assign bus4.op        = op;
  assign bus4.addr_ctl  = addr_ctl;
  assign bus4.mem_wait  = mem_wait;
  assign bus4.mem_ready = mem_ready;

  microsequencer #(.UPC_W(4), .CNT_W(16)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  microsequencer #(.UPC_W(4), .CNT_W(4)) u_dut4 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus4.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [1:0] ac);
    addr_ctl = ac;
    @(posedge clk);
    #1;
  endtask

  logic [6:0]  sw_op  [8];
  logic [1:0]  sw_ac  [8];
  logic [3:0]  sw_exp [8];
  logic [15:0] exp_cnt;

  initial begin
    sw_op[0] = 7'b0110011; sw_ac[0] = 2'b01; sw_exp[0] = 4'd6;
    sw_op[1] = 7'b0010011; sw_ac[1] = 2'b01; sw_exp[1] = 4'd8;
    sw_op[2] = 7'b1101111; sw_ac[2] = 2'b01; sw_exp[2] = 4'd9;
    sw_op[3] = 7'b1100011; sw_ac[3] = 2'b01; sw_exp[3] = 4'd10;
    sw_op[4] = 7'b0000011; sw_ac[4] = 2'b01; sw_exp[4] = 4'd2;
    sw_op[5] = 7'b0100011; sw_ac[5] = 2'b01; sw_exp[5] = 4'd2;
    sw_op[6] = 7'b0000011; sw_ac[6] = 2'b10; sw_exp[6] = 4'd3;
    sw_op[7] = 7'b0100011; sw_ac[7] = 2'b10; sw_exp[7] = 4'd5;

    // Reset state
    #2;
    check("rst_upc", 32'(bus.upc), 0);
    check("rst_retire", 32'(bus.retire), 0);
    check("rst_illegal", 32'(bus.illegal_op), 0);
    check("rst_cnt", 32'(bus.instr_count), 0);
    check("rst_stall", 32'(bus.stall), 0);
    #10 reset_n = 1'b1;

    // Idle loop
    step(2'b00);
    check("idle_upc", 32'(bus.upc), 0);
    check("idle_retire", 32'(bus.retire), 0);

    // lw flow
    op = 7'b0000011;
    step(2'b11); check("lw_upc1", 32'(bus.upc), 1);
    step(2'b01); check("lw_upc2", 32'(bus.upc), 2);
    step(2'b10); check("lw_upc3", 32'(bus.upc), 3);
    step(2'b11); check("lw_upc4", 32'(bus.upc), 4);
    check("lw_noretire", 32'(bus.retire), 0);
    step(2'b00); check("lw_upc0", 32'(bus.upc), 0);
    check("lw_retire", 32'(bus.retire), 1);
    check("lw_cnt", 32'(bus.instr_count), 1);
    step(2'b00); check("lw_retire_pulse", 32'(bus.retire), 0);
    check("lw_cnt_hold", 32'(bus.instr_count), 1);

    // Stall at upc=3 for four cycles
    step(2'b11); step(2'b01); step(2'b10);
    check("st_upc3", 32'(bus.upc), 3);
    mem_wait = 1'b1; mem_ready = 1'b0; addr_ctl = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1 check("st_stall_hi", 32'(bus.stall), 1);
      step(2'b11);
      check("st_upc_held", 32'(bus.upc), 3);
    end
    mem_ready = 1'b1;
    #1 check("st_stall_lo", 32'(bus.stall), 0);
    step(2'b11); check("st_advance", 32'(bus.upc), 4);
    mem_wait = 1'b0; mem_ready = 1'b0;
    mem_wait = 1'b1;
    step(2'b00); check("st_fetch_held", 32'(bus.upc), 4);
    check("st_fetch_noretire", 32'(bus.retire), 0);
    mem_wait = 1'b0;
    step(2'b00); check("st_fetch_upc", 32'(bus.upc), 0);
    check("st_retire", 32'(bus.retire), 1);
    check("st_cnt", 32'(bus.instr_count), 2);

    // Dispatch sweep
    for (int i = 0; i < 8; i++) begin
      op = sw_op[i];
      step(sw_ac[i]);
      check($sformatf("sweep%0d_upc", i), 32'(bus.upc), 32'(sw_exp[i]));
      step(2'b00);
      check($sformatf("sweep%0d_retire", i), 32'(bus.retire), 1);
    end
    check("sweep_cnt", 32'(bus.instr_count), 10);
    check("sweep_illegal", 32'(bus.illegal_op), 0);

    // Stall outranks an illegal dispatch
    op = 7'b1111111; mem_wait = 1'b1; mem_ready = 1'b0;
    step(2'b01);
    check("stpri_upc", 32'(bus.upc), 0);
    check("stpri_illegal", 32'(bus.illegal_op), 0);
    mem_wait = 1'b0;

    // Async reset at upc=9 during a stall
    op = 7'b1101111;
    step(2'b01); check("ar_upc9", 32'(bus.upc), 9);
    mem_wait = 1'b1;
    step(2'b00); check("ar_held", 32'(bus.upc), 9);
    #2 reset_n = 1'b0;
    #1;
    check("ar_upc", 32'(bus.upc), 0);
    check("ar_retire", 32'(bus.retire), 0);
    check("ar_cnt", 32'(bus.instr_count), 0);
    check("ar_stall_cnt4", 32'(bus4.instr_count), 0);
    mem_wait = 1'b0;
    @(posedge clk); #2 reset_n = 1'b1;
    step(2'b00);
    check("ar_rel_upc", 32'(bus.upc), 0);
    check("ar_rel_retire", 32'(bus.retire), 0);
    step(2'b11); check("ar_first_seq", 32'(bus.upc), 1);
    step(2'b00); check("ar_first_retire", 32'(bus.retire), 1);

    // Counter wrap on the 4-bit instance
    for (int i = 0; i < 14; i++) begin
      step(2'b11); step(2'b00);
    end
    check("wrap_cnt4_ones", 32'(bus4.instr_count), 15);
    step(2'b11); step(2'b00);
    check("wrap_cnt4_zero", 32'(bus4.instr_count), 0);
    check("wrap_cnt16", 32'(bus.instr_count), 16);

`ifndef MICROSEQ_ILLEGAL_TRAP_EN
    // Sequential wrap of the micro-PC
    for (int i = 0; i < 15; i++) step(2'b11);
    check("upc_at15", 32'(bus.upc), 15);
    step(2'b11);
    check("upc_wrap", 32'(bus.upc), 0);
    check("upc_wrap_noretire", 32'(bus.retire), 0);
    exp_cnt = 16'd17;
`else
    exp_cnt = 16'd16;
`endif

    // Illegal opcode
    op = 7'b0000011;
    step(2'b11); check("il_upc1", 32'(bus.upc), 1);
    op = 7'b1111111;
    step(2'b01);
    check("il_flag", 32'(bus.illegal_op), 1);
`ifdef MICROSEQ_ILLEGAL_TRAP_EN
    check("il_trap_upc", 32'(bus.upc), 15);
    check("il_trap_retire", 32'(bus.retire), 0);
    step(2'b00); check("il_trap_hold_fetch", 32'(bus.upc), 15);
    check("il_trap_noretire", 32'(bus.retire), 0);
    step(2'b11); check("il_trap_hold_seq", 32'(bus.upc), 15);
`else
    check("il_upc0", 32'(bus.upc), 0);
    check("il_retire", 32'(bus.retire), 1);
    step(2'b11); check("il_resume", 32'(bus.upc), 1);
`endif
    check("il_cnt", 32'(bus.instr_count), 32'(exp_cnt));
    check("il_sticky", 32'(bus.illegal_op), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/microsequencer.md
MICROSEQUENCER -- requirements
Module: microsequencer

Interface
REQ-001 Parameter UPC_W, default 4, SHALL set the micro-PC width in bits.
REQ-002 Parameter CNT_W, default 16, SHALL set the retired-instruction counter width in bits.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 reset_n  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 op  input  7  SHALL carry the opcode field of the instruction register.
REQ-006 addr_ctl  input  2  SHALL be the next-address control from the current microword: 00 fetch, 01 dispatch1, 10 dispatch2, 11 sequential.
REQ-007 mem_wait  input  1  SHALL flag that the current micro-state needs memory completion.
REQ-008 mem_ready  input  1  SHALL flag memory completion in this cycle.
REQ-009 upc  output  UPC_W  SHALL be the current micro-PC, registered, used to address the microcode ROM.
REQ-010 stall  output  1  SHALL be combinational, high when mem_wait=1 and mem_ready=0.
REQ-011 retire  output  1  SHALL be a registered one-cycle pulse marking a return to fetch from a non-zero micro-state.
REQ-012 illegal_op  output  1  SHALL be a sticky registered flag for an unmapped opcode at dispatch.
REQ-013 instr_count  output  CNT_W  SHALL be the number of retired instructions.

Function
REQ-014 Dispatch table 1 SHALL map op as follows: 0110011 -> 6; 0010011 -> 8; 1101111 -> 9; 1100011 -> 10; 0000011 and 0100011 -> 2; any other op -> illegal.
REQ-015 Dispatch table 2 SHALL map op as follows: 0000011 -> 3; 0100011 -> 5; any other op -> illegal. Both tables SHALL be internal and fully specified, with no latches.
REQ-016 When stall=1, the next upc SHALL equal upc, and retire and instr_count SHALL hold.
REQ-017 When stall=0, the next upc SHALL be:
- fetch -> 0
- sequential -> upc+1, wrapping modulo 2^UPC_W
- dispatch1 or dispatch2 -> the table value
REQ-018 Next-address latency SHALL be exactly one cycle; there SHALL be no combinational path from op or addr_ctl to upc.
REQ-019 retire SHALL be 1 in the cycle after an unstalled fetch taken while upc!=0; otherwise it SHALL be 0.
REQ-020 instr_count SHALL increment by 1 on every retire pulse and wrap from all-ones to 0.
REQ-021 Illegal dispatch SHALL set illegal_op=1; illegal_op SHALL clear only on reset.
REQ-022 Illegal-dispatch target SHALL follow REQ-034 and REQ-035.
REQ-023 Simultaneous events: stall SHALL take priority over any dispatch, including an illegal one. illegal_op SHALL set only in an unstalled cycle.
REQ-024 An unstalled fetch from upc=0 SHALL remain at 0 without retiring; this is the idle loop.

Reset
REQ-025 Asserting reset_n=0 SHALL immediately force upc=0, retire=0, illegal_op=0 and instr_count=0, independent of clk.
REQ-026 Reset asserted mid-instruction, including during a stall, SHALL abandon the instruction without a retire pulse.
REQ-027 After reset_n deasserts, the first rising edge SHALL evaluate addr_ctl normally from upc=0.

Configuration
REQ-028 Macro MICROSEQ_ILLEGAL_TRAP_EN SHALL select the illegal-dispatch behaviour.
REQ-029 With MICROSEQ_ILLEGAL_TRAP_EN defined, illegal dispatch SHALL go to upc = all-ones, the trap state.
REQ-030 In the trap state, upc SHALL hold regardless of addr_ctl until reset.
REQ-031 In the trap state, no retire pulse SHALL occur.
REQ-032 With MICROSEQ_ILLEGAL_TRAP_EN undefined, illegal dispatch SHALL go to upc=0.
REQ-033 That return to upc=0 SHALL produce a retire pulse, so the instruction is treated as a NOP.
REQ-034 Illegal-dispatch target, trap build: upc = all-ones.
REQ-035 Illegal-dispatch target, non-trap build: upc = 0.
REQ-036 illegal_op SHALL set on illegal dispatch in both builds.

Verification
REQ-037 lw flow: op=0000011, addr_ctl sequence 11,01,10,11,00 from upc=0 -> upc goes 1,2,3,4,0; retire=1 once; instr_count=1.
REQ-038 Stall: at upc=3 apply mem_wait=1, mem_ready=0 for 4 cycles then mem_ready=1 -> upc held at 3 for 4 cycles, then advances; stall=1 for exactly 4 cycles.
REQ-039 Illegal opcode: op=1111111 with dispatch1 -> illegal_op=1. With the macro: upc=15 and held, no retire. Without the macro: upc=0, retire=1.
REQ-040 Wrap: preload instr_count to 16'hFFFF through 65535 retires, then one more retire -> instr_count=0; separately, sequential at upc=15 in the non-trap build -> upc=0.
REQ-041 Async reset: drop reset_n between clock edges at upc=9 during a stall -> upc=0 and all outputs 0 immediately; no retire after release.
REQ-042 Dispatch sweep: each of the six mapped opcodes under dispatch1, and lw/sw under dispatch2 -> targets per REQ-014 and REQ-015; illegal_op stays 0.
